// File: rtl/chan_eq_param.sv
// chan_eq_param: per-bin frequency-domain channel equaliser placed after the FFT.
//   Training symbols (sign-corrected by a runtime reference mask) are averaged into a
//   per-bin channel estimate H. Each selected data bin x is then emitted as
//   sat((x*conj(H)) >>> PROD_SHIFT), with sat(|H|^2 >>> PROD_SHIFT) alongside.
//   A mid-packet re-train is taken at the next symbol boundary.
// Ports:
//   clock, reset (sync, active-high), enable (low freezes all state)
//   start            pulse: abort and train a new packet
//   retrain          pulse: re-estimate H at the next symbol boundary (DATA only)
//   ref_sign         per-bin training negate mask, sampled when training is (re)entered
//   data_mask        bins emitted as data, sampled at bin 0 of each data symbol
//   pilot_mask       bins emitted flagged as pilot, sampled with data_mask
//   sample_in        {i,q} input bin, natural order; sample_in_strobe qualifies it
//   sample_out       {i,q} equalised bin; mag_sq_out |H|^2; out_index bin number
//   out_pilot        emitted bin is a pilot; sample_out_strobe qualifies outputs
//   train_done       one-cycle pulse when H is final
//   symbol_count     data symbols completed since start (saturating)
//   state            0 idle, 1 train, 2 data
module chan_eq_param #(
  parameter int unsigned DW         = 16,
  parameter int unsigned NFFT_LOG2  = 6,
  parameter int unsigned AVG_LOG2   = 1,
  parameter int unsigned OW         = 16,
  parameter int unsigned PROD_SHIFT = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      retrain,
  input  logic [(1<<NFFT_LOG2)-1:0] ref_sign,
  input  logic [(1<<NFFT_LOG2)-1:0] data_mask,
  input  logic [(1<<NFFT_LOG2)-1:0] pilot_mask,
  input  logic [2*DW-1:0]           sample_in,
  input  logic                      sample_in_strobe,
  output logic [2*OW-1:0]           sample_out,
  output logic [OW-1:0]             mag_sq_out,
  output logic [NFFT_LOG2-1:0]      out_index,
  output logic                      out_pilot,
  output logic                      sample_out_strobe,
  output logic                      train_done,
  output logic [15:0]               symbol_count,
  output logic [1:0]                state
);

  localparam int unsigned NFFT = 1 << NFFT_LOG2;
  localparam int unsigned AW   = DW + AVG_LOG2;
  localparam int unsigned PW   = 2 * DW + 1;
  localparam int unsigned TW   = AVG_LOG2 + 1;
  localparam logic [NFFT_LOG2-1:0] LastBin = NFFT_LOG2'(NFFT - 1);
  localparam logic [TW-1:0]        LastTrn = TW'((1 << AVG_LOG2) - 1);
  localparam logic signed [PW-1:0] CompMax = PW'((1 << (OW - 1)) - 1);
  localparam logic signed [PW-1:0] CompMin = -CompMax;
  localparam logic signed [PW-1:0] MagMax  = PW'((1 << OW) - 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StTrain = 2'd1, StData = 2'd2} state_e;

  // Control state
  state_e                 state_q, state_d;
  logic [NFFT_LOG2-1:0]   bin_q, bin_d;
  logic [TW-1:0]          trn_q, trn_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [NFFT-1:0]        sign_q, sign_d;
  logic [NFFT-1:0]        dmask_q, dmask_d;
  logic [NFFT-1:0]        pmask_q, pmask_d;
  logic                   done_q, done_d;

  // Channel accumulators (no reset: contents are always rewritten by trn 0)
  logic signed [AW-1:0]   acc_i [NFFT];
  logic signed [AW-1:0]   acc_q [NFFT];
  logic                   acc_we;
  logic [NFFT_LOG2-1:0]   acc_waddr;
  logic signed [AW-1:0]   acc_wi, acc_wq;

  // Pipeline
  logic                   s1_load, s1_pilot_d;
  logic signed [DW-1:0]   h_i, h_q;
  logic                   s1_valid_q, s1_pilot_q;
  logic [NFFT_LOG2-1:0]   s1_idx_q;
  logic signed [DW-1:0]   s1_xi_q, s1_xq_q, s1_hi_q, s1_hq_q;
  logic                   s2_valid_q, s2_pilot_q;
  logic [NFFT_LOG2-1:0]   s2_idx_q;
  logic signed [2*DW-1:0] s2_pii_q, s2_pqq_q, s2_pqi_q, s2_piq_q, s2_hii_q, s2_hqq_q;
  logic                   out_valid_q;

  logic signed [DW-1:0]   x_i, x_q;
  state_e                 eff_state;
  logic [NFFT_LOG2-1:0]   eff_bin;
  logic [TW-1:0]          eff_trn;
  logic [NFFT-1:0]        eff_sign;
  logic signed [AW-1:0]   rd_i, rd_q, v_i, v_q;
  logic                   dm_eff, pm_eff;

  assign x_i = sample_in[2*DW-1:DW];
  assign x_q = sample_in[DW-1:0];

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    trn_d      = trn_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    sign_d     = sign_q;
    dmask_d    = dmask_q;
    pmask_d    = pmask_q;
    done_d     = 1'b0;
    acc_we     = 1'b0;
    acc_waddr  = bin_q;
    acc_wi     = '0;
    acc_wq     = '0;
    s1_load    = 1'b0;
    s1_pilot_d = 1'b0;

    // Resolve abort / immediate re-train first; a coincident sample then trains bin 0.
    eff_state = state_q;
    eff_bin   = bin_q;
    eff_trn   = trn_q;
    eff_sign  = sign_q;
    if (start) begin
      eff_state = StTrain;
      eff_bin   = '0;
      eff_trn   = '0;
      eff_sign  = ref_sign;
      cnt_d     = '0;
      pend_d    = 1'b0;
    end else if (state_q == StData && (retrain || pend_q) && bin_q == '0) begin
      eff_state = StTrain;
      eff_trn   = '0;
      eff_sign  = ref_sign;
      pend_d    = 1'b0;
    end else if (state_q == StData && retrain) begin
      pend_d = 1'b1;
    end
    state_d = eff_state;
    bin_d   = eff_bin;
    trn_d   = eff_trn;
    sign_d  = eff_sign;

    rd_i   = acc_i[eff_bin];
    rd_q   = acc_q[eff_bin];
    v_i    = eff_sign[eff_bin] ? -AW'(x_i) : AW'(x_i);
    v_q    = eff_sign[eff_bin] ? -AW'(x_q) : AW'(x_q);
    h_i    = DW'(rd_i >>> AVG_LOG2);
    h_q    = DW'(rd_q >>> AVG_LOG2);
    // Masks are taken live at bin 0 and from the latch for the rest of the symbol
    dm_eff = (eff_bin == '0) ? data_mask[eff_bin] : dmask_q[eff_bin];
    pm_eff = (eff_bin == '0) ? pilot_mask[eff_bin] : pmask_q[eff_bin];

    if (sample_in_strobe) begin
      case (eff_state)
        StTrain: begin
          acc_we    = 1'b1;
          acc_waddr = eff_bin;
          acc_wi    = (eff_trn == '0) ? v_i : rd_i + v_i;
          acc_wq    = (eff_trn == '0) ? v_q : rd_q + v_q;
          bin_d     = eff_bin + NFFT_LOG2'(1);
          if (eff_bin == LastBin) begin
            trn_d = eff_trn + TW'(1);
            if (eff_trn == LastTrn) begin
              state_d = StData;
              trn_d   = '0;
              done_d  = 1'b1;
            end
          end
        end
        StData: begin
          if (eff_bin == '0) begin
            dmask_d = data_mask;
            pmask_d = pilot_mask;
          end
          s1_load    = dm_eff | pm_eff;
          s1_pilot_d = pm_eff;
          bin_d      = eff_bin + NFFT_LOG2'(1);
          if (eff_bin == LastBin) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (pend_d) begin
              state_d = StTrain;
              trn_d   = '0;
              sign_d  = ref_sign;
              pend_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enable && acc_we) begin
      acc_i[acc_waddr] <= acc_wi;
      acc_q[acc_waddr] <= acc_wq;
    end
  end

  // Stage 3: sum, shift, saturate
  logic signed [PW-1:0] re_sh, im_sh, mag_sh;

  always_comb begin
    re_sh  = (PW'(s2_pii_q) + PW'(s2_pqq_q)) >>> PROD_SHIFT;
    im_sh  = (PW'(s2_pqi_q) - PW'(s2_piq_q)) >>> PROD_SHIFT;
    mag_sh = (PW'(s2_hii_q) + PW'(s2_hqq_q)) >>> PROD_SHIFT;
  end

  function automatic logic [OW-1:0] sat_comp(input logic signed [PW-1:0] v);
    if (v > CompMax) return CompMax[OW-1:0];
    else if (v < CompMin) return CompMin[OW-1:0];
    else return v[OW-1:0];
  endfunction

  // Datapath registers without reset; valids below are reset to flush the pipe
  always_ff @(posedge clock) begin
    if (enable) begin
      if (s1_load) begin
        s1_xi_q    <= x_i;
        s1_xq_q    <= x_q;
        s1_hi_q    <= h_i;
        s1_hq_q    <= h_q;
        s1_idx_q   <= eff_bin;
        s1_pilot_q <= s1_pilot_d;
      end
      if (s1_valid_q) begin
        s2_pii_q   <= (2*DW)'(s1_xi_q) * (2*DW)'(s1_hi_q);
        s2_pqq_q   <= (2*DW)'(s1_xq_q) * (2*DW)'(s1_hq_q);
        s2_pqi_q   <= (2*DW)'(s1_xq_q) * (2*DW)'(s1_hi_q);
        s2_piq_q   <= (2*DW)'(s1_xi_q) * (2*DW)'(s1_hq_q);
        s2_hii_q   <= (2*DW)'(s1_hi_q) * (2*DW)'(s1_hi_q);
        s2_hqq_q   <= (2*DW)'(s1_hq_q) * (2*DW)'(s1_hq_q);
        s2_idx_q   <= s1_idx_q;
        s2_pilot_q <= s1_pilot_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      trn_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      sign_q      <= '0;
      dmask_q     <= '0;
      pmask_q     <= '0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sample_out  <= '0;
      mag_sq_out  <= '0;
      out_index   <= '0;
      out_pilot   <= 1'b0;
    end else if (enable) begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      trn_q       <= trn_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      sign_q      <= sign_d;
      dmask_q     <= dmask_d;
      pmask_q     <= pmask_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_load;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        sample_out <= {sat_comp(re_sh), sat_comp(im_sh)};
        mag_sq_out <= (mag_sh > MagMax) ? '1 : mag_sh[OW-1:0];
        out_index  <= s2_idx_q;
        out_pilot  <= s2_pilot_q;
      end
    end
  end

  assign sample_out_strobe = out_valid_q & enable;
  assign train_done        = done_q & enable;
  assign symbol_count      = cnt_q;
  assign state             = state_q;

endmodule
